// File: rtl/mux_tree_scheduler_pkg.sv
// rtl/mux_tree_scheduler_pkg.sv - shared FSM encoding and width constants for the mux-tree scheduler
// Purpose: state encoding and result-width constant shared by the scheduler files.
// Ports: none (package).
package mux_tree_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_t;

    // (d << 2) + 1 grows the operand by exactly two bits, so it can never overflow.
    localparam int RES_EXTRA_W = 2;

endpackage

// File: rtl/mux_tree_scheduler_rr_arbiter_core.sv
// rtl/mux_tree_scheduler_rr_arbiter_core.sv - combinational round-robin pick from a rotating pointer
// Purpose: find the first valid requester at or above rr_ptr, wrapping to 0.
// Ports:
//   req_valid  in   NUM_REQ  per-requester valid
//   rr_ptr     in   SRC_W    index searched first
//   grant      out  NUM_REQ  one-hot winner (all-zero when nothing is valid)
//   grant_idx  out  SRC_W    index of the winner (0 when nothing is valid)
//   grant_any  out  1        some requester is valid
module rr_arbiter_core #(
    parameter int NUM_REQ = 4,
    parameter int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [SRC_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [SRC_W-1:0]   grant_idx,
    output logic               grant_any
);

    logic [SRC_W-1:0] w_idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        w_idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = SRC_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!grant_any && req_valid[w_idx]) begin
                grant_any        = 1'b1;
                grant[w_idx]     = 1'b1;
                grant_idx        = w_idx;
            end
        end
    end

endmodule

// File: rtl/mux_tree_scheduler.sv
// rtl/mux_tree_scheduler.sv - round-robin shared (d << 2) + 1 datapath with held result register
// Purpose: arbitrate NUM_REQ requesters onto one registered compute stage and hold each
//          result until the consumer accepts it.
// Ports:
//   clk        in   1               clock, rising edge
//   rst_n      in   1               synchronous active-low reset
//   req_valid  in   NUM_REQ         per-requester valid
//   req_data   in   NUM_REQ*DATA_W  operands, requester i at [i*DATA_W +: DATA_W]
//   req_ready  out  NUM_REQ         one-hot grant, combinational
//   out_valid  out  1               result available
//   out_ready  in   1               consumer accepts result
//   out_data   out  DATA_W+2        (operand << 2) + 1
//   out_src    out  SRC_W           requester that produced out_data
//   busy       out  1               FSM not idle
module mux_tree_scheduler
    import mux_tree_scheduler_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 8,
    localparam int SRC_W   = $clog2(NUM_REQ),
    localparam int RES_W   = DATA_W + RES_EXTRA_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [RES_W-1:0]           out_data,
    output logic [SRC_W-1:0]           out_src,
    output logic                       busy
);

    sched_state_t       r_state;
    sched_state_t       w_state_next;
    logic [SRC_W-1:0]   r_rr_ptr;
    logic [DATA_W-1:0]  r_op;
    logic [SRC_W-1:0]   r_src;
    logic [RES_W-1:0]   r_out_data;
    logic [SRC_W-1:0]   r_out_src;
    logic               r_out_valid;

    logic [NUM_REQ-1:0] w_grant;
    logic [SRC_W-1:0]   w_gidx;
    logic               w_gany;
    logic               w_window;
    logic               w_grant_en;
    logic [SRC_W-1:0]   w_ptr_next;
    logic [DATA_W-1:0]  w_sel_data;
    logic [RES_W-1:0]   w_result;

    rr_arbiter_core #(
        .NUM_REQ (NUM_REQ),
        .SRC_W   (SRC_W)
    ) u_arb (
        .req_valid (req_valid),
        .rr_ptr    (r_rr_ptr),
        .grant     (w_grant),
        .grant_idx (w_gidx),
        .grant_any (w_gany)
    );

    // A draining result that is being taken this cycle frees the datapath, so a new
    // grant can overlap the retirement and sustain one result per two cycles.
    assign w_window   = (r_state == ST_IDLE) || ((r_state == ST_DRAIN) && out_ready);
    // Reset gates the grant so no requester sees an accept that is then discarded.
    assign w_grant_en = rst_n && w_window && w_gany;
    assign req_ready  = w_grant_en ? w_grant : '0;

    assign w_ptr_next = (int'(w_gidx) == NUM_REQ - 1) ? '0 : w_gidx + 1'b1;
    // Only the granted slice is read, so X on other requesters cannot leak through.
    assign w_sel_data = req_data[w_gidx*DATA_W +: DATA_W];
    assign w_result   = ({{RES_EXTRA_W{1'b0}}, r_op} << 2) | RES_W'(1);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_grant_en) w_state_next = ST_CALC;
            ST_CALC:  w_state_next = ST_DRAIN;
            ST_DRAIN: begin
                if (out_ready) w_state_next = w_grant_en ? ST_CALC : ST_IDLE;
            end
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_op        <= '0;
            r_src       <= '0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_grant_en) begin
                r_op     <= w_sel_data;
                r_src    <= w_gidx;
                r_rr_ptr <= w_ptr_next;
            end
            if (r_state == ST_CALC) begin
                r_out_data  <= w_result;
                r_out_src   <= r_src;
                r_out_valid <= 1'b1;
            end else if ((r_state == ST_DRAIN) && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mux_tree_scheduler.sv
// tb/tb_mux_tree_scheduler.sv - directed self-checking bench for mux_tree_scheduler
module tb_mux_tree_scheduler;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_W+1:0]         out_data;
    logic [1:0]                out_src;
    logic                      busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0] exp_res [4];

    mux_tree_scheduler #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // results for operands 10,20,30,40 on requesters 0..3
        exp_res[0] = 10'h041;
        exp_res[1] = 10'h081;
        exp_res[2] = 10'h0C1;
        exp_res[3] = 10'h101;

        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b0;

        // 1. reset and idle
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            settle();
            chk("idle_req_ready", 32'(req_ready), 32'h0);
            chk("idle_out_valid", 32'(out_valid), 32'h0);
            chk("idle_busy",      32'(busy),      32'h0);
            chk("idle_out_data",  32'(out_data),  32'h0);
            tick();
        end

        // 2. single request, other operands X
        req_data  = 'x;
        req_data[2*DATA_W +: DATA_W] = 8'h3F;
        req_valid = 4'b0100;
        out_ready = 1'b1;
        settle();
        chk("single_grant", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        settle();
        chk("single_calc_ready", 32'(req_ready), 32'h0);
        chk("single_calc_valid", 32'(out_valid), 32'h0);
        chk("single_calc_busy",  32'(busy),      32'h1);
        tick();
        chk("single_out_valid", 32'(out_valid), 32'h1);
        chk("single_out_data",  32'(out_data),  32'h0FD);
        chk("single_out_src",   32'(out_src),   32'h2);
        tick();
        chk("single_retired_valid", 32'(out_valid), 32'h0);
        chk("single_retired_busy",  32'(busy),      32'h0);

        // 3. all four valid, continuous drain
        do_reset();
        req_data  = {8'h40, 8'h30, 8'h20, 8'h10};
        req_valid = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            settle();
            chk("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
            if (k > 0) begin
                chk("rr_out_valid", 32'(out_valid), 32'h1);
                chk("rr_out_src",   32'(out_src),   32'((k - 1) % 4));
                chk("rr_out_data",  32'(out_data),  32'(exp_res[(k - 1) % 4]));
            end
            tick();
            chk("rr_calc_ready", 32'(req_ready), 32'h0);
            chk("rr_calc_valid", 32'(out_valid), 32'h0);
            tick();
        end
        req_valid = '0;
        chk("rr_last_valid", 32'(out_valid), 32'h1);
        chk("rr_last_src",   32'(out_src),   32'h1);
        chk("rr_last_data",  32'(out_data),  32'h081);
        tick();
        chk("rr_idle_busy", 32'(busy), 32'h0);

        // 4. operand extremes, second grant overlapping the drain
        do_reset();
        req_data  = '0;
        req_data[0 +: DATA_W] = 8'hFF;
        req_valid = 4'b0001;
        settle();
        chk("ff_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        tick();
        chk("ff_out_data", 32'(out_data), 32'h3FD);
        chk("ff_out_src",  32'(out_src),  32'h0);
        req_data  = 'x;
        req_data[1*DATA_W +: DATA_W] = 8'h00;
        req_valid = 4'b0010;
        settle();
        chk("zero_grant_in_drain", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        tick();
        chk("zero_out_valid", 32'(out_valid), 32'h1);
        chk("zero_out_data",  32'(out_data),  32'h001);
        chk("zero_out_src",   32'(out_src),   32'h1);
        tick();

        // 5. stall with requester 1 waiting (rr_ptr is 2 here)
        req_data  = '0;
        req_data[3*DATA_W +: DATA_W] = 8'h22;
        req_data[1*DATA_W +: DATA_W] = 8'h55;
        req_valid = 4'b1000;
        out_ready = 1'b0;
        settle();
        chk("stall_first_grant", 32'(req_ready), 32'h8);
        tick();
        req_valid = 4'b0010;
        settle();
        chk("stall_calc_ready", 32'(req_ready), 32'h0);
        tick();
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("stall_valid", 32'(out_valid), 32'h1);
            chk("stall_data",  32'(out_data),  32'h089);
            chk("stall_src",   32'(out_src),   32'h3);
            chk("stall_ready", 32'(req_ready), 32'h0);
            tick();
        end
        out_ready = 1'b1;
        settle();
        chk("stall_release_grant", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        tick();
        chk("stall_next_data", 32'(out_data), 32'h155);
        chk("stall_next_src",  32'(out_src),  32'h1);
        tick();

        // 6a. reset while in CALC (rr_ptr is 2 here)
        req_data  = {8'h04, 8'h03, 8'h02, 8'h01};
        req_valid = 4'b0100;
        out_ready = 1'b0;
        settle();
        chk("rst_calc_pre_grant", 32'(req_ready), 32'h4);
        tick();
        chk("rst_calc_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        req_valid = 4'b1111;
        tick();
        rst_n = 1'b1;
        req_valid = 4'b1010;
        settle();
        chk("rst_calc_valid", 32'(out_valid), 32'h0);
        chk("rst_calc_busy2", 32'(busy),      32'h0);
        chk("rst_calc_first_grant", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        tick();
        chk("rst_drain_pre_valid", 32'(out_valid), 32'h1);

        // 6b. reset while in DRAIN, with an open window and valid requests
        rst_n     = 1'b0;
        out_ready = 1'b1;
        req_valid = 4'b1111;
        settle();
        chk("rst_cycle_no_ready", 32'(req_ready), 32'h0);
        tick();
        rst_n = 1'b1;
        req_valid = 4'b1001;
        settle();
        chk("rst_drain_valid", 32'(out_valid), 32'h0);
        chk("rst_drain_data",  32'(out_data),  32'h0);
        chk("rst_drain_src",   32'(out_src),   32'h0);
        chk("rst_drain_busy",  32'(busy),      32'h0);
        chk("rst_drain_first_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        tick();
        chk("rst_drain_result", 32'(out_data), 32'h005);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
